trivium_ks_arbiter: RTL and testbench
=====================================

TRIVIUM_KS_ARBITER -- requirements
Module: trivium_ks_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of keystream requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 80, meaning keystream block width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rekey  input  1  single-cycle pulse requesting reload with key_in/iv_in.
REQ-006 SHALL have ports key_in, iv_in  input  80 each  key and IV, sampled on an accepted rekey.
REQ-007 SHALL have port req  input  N_REQ  per-requester block request, held high until served.
REQ-008 SHALL have port ks_valid  output  N_REQ  one-hot, single-cycle delivery strobe.
REQ-009 SHALL have port ks_data  output  DATA_WIDTH  registered keystream block, valid while ks_valid nonzero.
REQ-010 SHALL have port busy  output  1  high in every state other than READY.
REQ-011 SHALL have ports core_rst, core_next_data  output  1 each, plus core_key, core_iv  output  80 each; core_end_block  input  1; core_block  input  DATA_WIDTH; connected to the keystream wrapper.

Function
REQ-012 SHALL implement FSM states IDLE, KEYLOAD, FILL, READY.
REQ-013 SHALL stay in IDLE, ignoring req, until the first rekey pulse.
REQ-014 SHALL, on rekey in any state, latch key_in/iv_in into core_key/core_iv and enter KEYLOAD.
REQ-015 SHALL assert core_rst high for exactly one cycle in KEYLOAD, then enter FILL.
REQ-016 SHALL remain in FILL until core_end_block=1, then enter READY.
REQ-017 SHALL, in READY with at least one req bit set, grant one requester, register core_block into ks_data, assert that requester's ks_valid for one cycle, pulse core_next_data for one cycle, and return to FILL.
REQ-018 SHALL deliver on the clock edge following the cycle in which req is seen high in READY; never more than one grant per block.
REQ-019 SHALL give rekey priority over a pending grant in the same cycle: no ks_valid, no core_next_data.
REQ-020 SHALL, on rekey during FILL, abandon the partial block; no stale block is ever delivered.
REQ-021 SHALL ignore req bits that drop before grant; ks_data SHALL hold its value between deliveries.

Reset
REQ-022 SHALL on rst_n low asynchronously force: state IDLE, ks_valid 0, ks_data 0, core_next_data 0, core_key 0, core_iv 0, round-robin pointer 0, busy 1.
REQ-023 SHALL hold core_rst high while rst_n is low and for the first cycle after release.
REQ-024 SHALL, on reset mid-block, discard all progress and require a new rekey.

Configuration
REQ-025 SHALL support macro TRIVIUM_ARB_RR_EN: defined -> round-robin grant, search starting at the index after the last granted requester, wrapping from N_REQ-1 to 0.
REQ-026 SHALL, without TRIVIUM_ARB_RR_EN, use fixed priority, lowest index wins; pointer logic is absent.

Structure
REQ-027 SHALL place the FSM state enum (2-bit) and the default-width constants in package trivium_arb_pkg.
REQ-028 SHALL implement grant selection in sub-module rr_grant (req vector and pointer in, one-hot grant out, combinational); the keystream wrapper is instantiated outside this block.

Verification
REQ-029 SHALL cover: reset, rekey key=0x0, iv=0x0, req=0001 -> one core_rst pulse, ks_valid=0001 once, ks_data matches the 80-bit reference keystream block 0.
REQ-030 SHALL cover: RR build, req=1111 held for 4 blocks -> ks_valid order 0001, 0010, 0100, 1000; fixed build -> 0001 four times.
REQ-031 SHALL cover: rekey and req both high in READY -> no ks_valid that cycle, core_rst pulses next cycle, first delivery afterwards equals block 0 of the new key.
REQ-032 SHALL cover: rekey mid-FILL -> partial block never delivered; core_next_data stays 0 until the next READY.
REQ-033 SHALL cover: rst_n low during FILL -> ks_valid 0, state IDLE; req=1111 without rekey -> no ks_valid for 200 cycles.
REQ-034 SHALL cover: req pulses high one cycle during FILL then drops -> no delivery and FSM stays READY once the block completes.

Source files
------------

// File: rtl/trivium_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trivium_arb_pkg
//  Purpose  : Shared state encoding and default widths for the Trivium
//             keystream arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package trivium_arb_pkg;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DATA_WIDTH = 80;
  localparam int KEY_W          = 80;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_KEYLOAD = 2'd1;
  localparam logic [1:0] ST_FILL    = 2'd2;
  localparam logic [1:0] ST_READY   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    KEYLOAD = ST_KEYLOAD,
    FILL    = ST_FILL,
    READY   = ST_READY
  } arb_state_e;

endpackage : trivium_arb_pkg
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant
//  Purpose  : Combinational one-hot grant. The search starts at index ptr and
//             wraps; with ptr tied to zero it degenerates to lowest-index-wins.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_grant #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  logic [N_REQ-1:0] rot_req_w;
  logic [N_REQ-1:0] rot_gnt_w;

  // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_req_w = N_REQ'({req, req} >> ptr);
    rot_gnt_w = rot_req_w & (~rot_req_w + N_REQ'(1));
    grant     = N_REQ'(({rot_gnt_w, rot_gnt_w} << ptr) >> N_REQ);
  end

endmodule : rr_grant
`default_nettype wire

// File: rtl/trivium_ks_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : trivium_ks_arbiter
//  Purpose  : Sequences an external Trivium keystream wrapper (rekey, fill)
//             and hands each finished keystream block to exactly one of
//             N_REQ requesters.
//  Config   : TRIVIUM_ARB_RR_EN defined -> round-robin grant;
//             undefined -> fixed priority, lowest index wins.
//  Revision : 1.0 - initial release
// ============================================================================
module trivium_ks_arbiter
  import trivium_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rekey,
  input  logic [KEY_W-1:0]      key_in,
  input  logic [KEY_W-1:0]      iv_in,
  input  logic [N_REQ-1:0]      req,
  output logic [N_REQ-1:0]      ks_valid,
  output logic [DATA_WIDTH-1:0] ks_data,
  output logic                  busy,
  output logic                  core_rst,
  output logic                  core_next_data,
  output logic [KEY_W-1:0]      core_key,
  output logic [KEY_W-1:0]      core_iv,
  input  logic                  core_end_block,
  input  logic [DATA_WIDTH-1:0] core_block
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e            state_q, state_d;
  logic [N_REQ-1:0]      ks_valid_q, ks_valid_d;
  logic [DATA_WIDTH-1:0] ks_data_q, ks_data_d;
  logic                  core_rst_q, core_rst_d;
  logic                  core_next_q, core_next_d;
  logic [KEY_W-1:0]      core_key_q, core_key_d;
  logic [KEY_W-1:0]      core_iv_q, core_iv_d;

  logic [PTR_W-1:0]      ptr_w;
  logic [N_REQ-1:0]      grant_w;
  logic                  grant_fire_w;

  rr_grant #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_grant (
    .req   (req),
    .ptr   (ptr_w),
    .grant (grant_w)
  );

  // A grant happens only in READY with a request present and no rekey.
  assign grant_fire_w = !rekey && (state_q == READY) && (|req);

`ifdef TRIVIUM_ARB_RR_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_idx_w;

  // Encode the one-hot grant and advance the pointer past it, wrapping.
  always_comb begin
    gnt_idx_w = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_w[i]) gnt_idx_w = PTR_W'(i);
    end
    ptr_d = ptr_q;
    if (grant_fire_w) begin
      ptr_d = (gnt_idx_w == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx_w + PTR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_w = ptr_q;
`else
  assign ptr_w = '0;
`endif

  // Next-state and output computation; rekey overrides everything else.
  always_comb begin
    state_d     = state_q;
    ks_valid_d  = '0;
    ks_data_d   = ks_data_q;
    core_next_d = 1'b0;
    core_key_d  = core_key_q;
    core_iv_d   = core_iv_q;
    if (rekey) begin
      core_key_d = key_in;
      core_iv_d  = iv_in;
      state_d    = KEYLOAD;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        KEYLOAD: state_d = FILL;
        // core_end_block still shows the previous block while the
        // next-data pulse is in flight, so it is ignored in that cycle.
        FILL: begin
          if (core_end_block && !core_next_q) state_d = READY;
        end
        READY: begin
          if (grant_fire_w) begin
            ks_valid_d  = grant_w;
            ks_data_d   = core_block;
            core_next_d = 1'b1;
            state_d     = FILL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    core_rst_d = (state_d == KEYLOAD);
  end

  // State and registered outputs; core_rst is held high through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ks_valid_q  <= '0;
      ks_data_q   <= '0;
      core_rst_q  <= 1'b1;
      core_next_q <= 1'b0;
      core_key_q  <= '0;
      core_iv_q   <= '0;
    end else begin
      state_q     <= state_d;
      ks_valid_q  <= ks_valid_d;
      ks_data_q   <= ks_data_d;
      core_rst_q  <= core_rst_d;
      core_next_q <= core_next_d;
      core_key_q  <= core_key_d;
      core_iv_q   <= core_iv_d;
    end
  end

  assign ks_valid       = ks_valid_q;
  assign ks_data        = ks_data_q;
  assign busy           = (state_q != READY);
  assign core_rst       = core_rst_q;
  assign core_next_data = core_next_q;
  assign core_key       = core_key_q;
  assign core_iv        = core_iv_q;

endmodule : trivium_ks_arbiter
`default_nettype wire

// File: tb/tb_trivium_ks_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trivium_ks_arbiter
//  Purpose  : Directed self-checking bench for trivium_ks_arbiter, with a
//             behavioural Trivium wrapper providing core_block/core_end_block.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trivium_ks_arbiter;
  import trivium_arb_pkg::*;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rekey = 1'b0;
  logic [79:0] key_in = '0;
  logic [79:0] iv_in = '0;
  logic [3:0]  req = '0;
  logic [3:0]  ks_valid;
  logic [79:0] ks_data;
  logic        busy, core_rst, core_next_data;
  logic [79:0] core_key, core_iv;
  logic        core_end_block = 1'b0;
  logic [79:0] core_block = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trivium_ks_arbiter #(.N_REQ(4), .DATA_WIDTH(80)) dut (
    .clk(clk), .rst_n(rst_n), .rekey(rekey), .key_in(key_in), .iv_in(iv_in),
    .req(req), .ks_valid(ks_valid), .ks_data(ks_data), .busy(busy),
    .core_rst(core_rst), .core_next_data(core_next_data), .core_key(core_key),
    .core_iv(core_iv), .core_end_block(core_end_block), .core_block(core_block)
  );

  // ---------------- Trivium reference functions ----------------
  function automatic logic [288:1] tri_load(input logic [79:0] k, input logic [79:0] v);
    logic [288:1] s;
    s = '0;
    s[80:1] = k;
    s[173:94] = v;
    s[288:286] = 3'b111;
    return s;
  endfunction

  function automatic logic [288:1] tri_step(input logic [288:1] s, output logic z);
    logic t1, t2, t3;
    t1 = s[66] ^ s[93];
    t2 = s[162] ^ s[177];
    t3 = s[243] ^ s[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[91] & s[92]) ^ s[171];
    t2 = t2 ^ (s[175] & s[176]) ^ s[264];
    t3 = t3 ^ (s[286] & s[287]) ^ s[69];
    return {s[287:178], t2, s[176:94], t1, s[92:1], t3};
  endfunction

  function automatic logic [288:1] tri_adv(input logic [288:1] s, input int n);
    logic [288:1] r;
    logic z;
    r = s;
    for (int i = 0; i < n; i++) r = tri_step(r, z);
    return r;
  endfunction

  function automatic logic [79:0] tri_block(input logic [288:1] s);
    logic [288:1] r;
    logic [79:0] b;
    logic z;
    r = s;
    b = '0;
    for (int i = 0; i < 80; i++) begin
      r = tri_step(r, z);
      b[i] = z;
    end
    return b;
  endfunction

  function automatic logic [79:0] exp_block(input logic [79:0] k, input logic [79:0] v, input int n);
    logic [288:1] s;
    s = tri_adv(tri_load(k, v), 1152);
    for (int j = 0; j < n; j++) s = tri_adv(s, 80);
    return tri_block(s);
  endfunction

  // ---------------- behavioural keystream wrapper ----------------
  logic [288:1] m_s = '0;
  int           m_cnt = 0;

  always @(posedge clk) begin
    if (core_rst) begin
      m_s            <= tri_adv(tri_load(core_key, core_iv), 1152);
      m_cnt          <= LAT;
      core_end_block <= 1'b0;
    end else if (core_next_data) begin
      m_cnt          <= LAT;
      core_end_block <= 1'b0;
    end else if (m_cnt == 1) begin
      core_block     <= tri_block(m_s);
      m_s            <= tri_adv(m_s, 80);
      core_end_block <= 1'b1;
      m_cnt          <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rekey(input logic [79:0] k, input logic [79:0] v);
    key_in = k;
    iv_in  = v;
    rekey  = 1'b1;
    tick();
    rekey  = 1'b0;
  endtask

  task automatic wait_ready(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (ks_valid !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    key_in = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    tick(); tick();
    checks++; if (ks_valid !== 4'b0)   begin failures++; $display("FAIL reset_ks_valid got=%b exp=0000", ks_valid); end
    checks++; if (ks_data !== 80'h0)   begin failures++; $display("FAIL reset_ks_data got=%h exp=0", ks_data); end
    checks++; if (core_next_data !== 1'b0) begin failures++; $display("FAIL reset_next_data got=%b exp=0", core_next_data); end
    checks++; if (core_key !== 80'h0)  begin failures++; $display("FAIL reset_core_key got=%h exp=0", core_key); end
    checks++; if (core_iv !== 80'h0)   begin failures++; $display("FAIL reset_core_iv got=%h exp=0", core_iv); end
    checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (core_rst !== 1'b1)   begin failures++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
    rst_n = 1'b1;
    #2;
    checks++; if (core_rst !== 1'b1)   begin failures++; $display("FAIL release_core_rst got=%b exp=1", core_rst); end
    tick();
    checks++; if (core_rst !== 1'b0)   begin failures++; $display("FAIL after_release_core_rst got=%b exp=0", core_rst); end
  endtask

  task automatic test_idle_ignore();
    bit bad;
    bad = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ks_valid !== 4'b0 || core_next_data !== 1'b0) bad = 1'b1;
    end
    req = 4'b0;
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL idle_no_delivery got=%b exp=0", bad); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL idle_state got=%0d exp=%0d", dut.state_q, IDLE); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL idle_busy got=%b exp=1", busy); end
  endtask

  task automatic test_basic();
    int rst_cnt, vcnt, ncnt;
    logic [3:0]  vseen;
    logic [79:0] dseen, expd;
    rst_cnt = 0; vcnt = 0; ncnt = 0; vseen = '0; dseen = '0;
    expd = exp_block(80'h0, 80'h0, 0);
    pulse_rekey(80'h0, 80'h0);
    checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL basic_core_rst got=%b exp=1", core_rst); end
    checks++; if (dut.state_q !== KEYLOAD) begin failures++; $display("FAIL basic_keyload got=%0d exp=%0d", dut.state_q, KEYLOAD); end
    req = 4'b0001;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (core_rst === 1'b1) rst_cnt++;
      if (core_next_data === 1'b1) ncnt++;
      if (ks_valid !== 4'b0) begin
        vcnt++;
        vseen = ks_valid;
        dseen = ks_data;
        req = 4'b0;
      end
    end
    checks++; if (rst_cnt !== 0) begin failures++; $display("FAIL basic_extra_core_rst got=%0d exp=0", rst_cnt); end
    checks++; if (vcnt !== 1) begin failures++; $display("FAIL basic_valid_count got=%0d exp=1", vcnt); end
    checks++; if (ncnt !== 1) begin failures++; $display("FAIL basic_next_count got=%0d exp=1", ncnt); end
    checks++; if (vseen !== 4'b0001) begin failures++; $display("FAIL basic_valid got=%b exp=0001", vseen); end
    checks++; if (dseen !== expd) begin failures++; $display("FAIL basic_data got=%h exp=%h", dseen, expd); end
    checks++; if (ks_data !== expd) begin failures++; $display("FAIL basic_data_hold got=%h exp=%h", ks_data, expd); end
  endtask

  task automatic test_multi();
    logic [79:0] k, v;
    logic [3:0]  vs [4];
    logic [79:0] ds [4];
    logic [3:0]  exp_order [4];
    int n;
    k = 80'h0123_4567_89AB_CDEF_1357;
    v = 80'hFEDC_BA98_7654_3210_2468;
`ifdef TRIVIUM_ARB_RR_EN
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100; exp_order[3] = 4'b1000;
`else
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0001; exp_order[2] = 4'b0001; exp_order[3] = 4'b0001;
`endif
    for (int i = 0; i < 4; i++) begin vs[i] = '0; ds[i] = '0; end
    n = 0;
    pulse_rekey(k, v);
    req = 4'b1111;
    for (int i = 0; i < 200 && n < 4; i++) begin
      tick();
      if (ks_valid !== 4'b0) begin
        vs[n] = ks_valid;
        ds[n] = ks_data;
        n++;
      end
    end
    req = 4'b0;
    checks++; if (n !== 4) begin failures++; $display("FAIL multi_count got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (vs[i] !== exp_order[i]) begin failures++; $display("FAIL multi_order[%0d] got=%b exp=%b", i, vs[i], exp_order[i]); end
      checks++; if (ds[i] !== exp_block(k, v, i)) begin failures++; $display("FAIL multi_data[%0d] got=%h exp=%h", i, ds[i], exp_block(k, v, i)); end
    end
  endtask

  task automatic test_rekey_priority();
    bit ok;
    logic [79:0] k, v;
    k = 80'hA5A5_5A5A_0F0F_F0F0_1234;
    v = 80'h0000_1111_2222_3333_4444;
    wait_ready(100, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL prio_ready_timeout got=%b exp=1", ok); end
    req = 4'b0001;
    key_in = k; iv_in = v; rekey = 1'b1;
    tick();
    rekey = 1'b0;
    checks++; if (ks_valid !== 4'b0) begin failures++; $display("FAIL prio_no_valid got=%b exp=0000", ks_valid); end
    checks++; if (core_next_data !== 1'b0) begin failures++; $display("FAIL prio_no_next got=%b exp=0", core_next_data); end
    checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL prio_core_rst got=%b exp=1", core_rst); end
    wait_valid(100, ok);
    req = 4'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL prio_valid_timeout got=%b exp=1", ok); end
    checks++; if (ks_valid !== 4'b0001) begin failures++; $display("FAIL prio_valid got=%b exp=0001", ks_valid); end
    checks++; if (ks_data !== exp_block(k, v, 0)) begin failures++; $display("FAIL prio_data got=%h exp=%h", ks_data, exp_block(k, v, 0)); end
  endtask

  task automatic test_rekey_mid_fill();
    bit ok, bad, rdy;
    logic [79:0] k, v;
    k = 80'h1111_2222_3333_4444_5555;
    v = 80'h9999_8888_7777_6666_5555;
    bad = 1'b0; rdy = 1'b0;
    wait_ready(100, ok);
    req = 4'b0010;
    wait_valid(10, ok);
    req = 4'b0;
    checks++; if (ks_valid !== 4'b0010) begin failures++; $display("FAIL midfill_first_valid got=%b exp=0010", ks_valid); end
    tick(); tick();
    checks++; if (dut.state_q !== FILL) begin failures++; $display("FAIL midfill_in_fill got=%0d exp=%0d", dut.state_q, FILL); end
    pulse_rekey(k, v);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy === 1'b0) begin rdy = 1'b1; break; end
      if (core_next_data !== 1'b0 || ks_valid !== 4'b0) bad = 1'b1;
    end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL midfill_ready_timeout got=%b exp=1", rdy); end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL midfill_quiet got=%b exp=0", bad); end
    req = 4'b0100;
    wait_valid(10, ok);
    req = 4'b0;
    checks++; if (ks_valid !== 4'b0100) begin failures++; $display("FAIL midfill_valid got=%b exp=0100", ks_valid); end
    checks++; if (ks_data !== exp_block(k, v, 0)) begin failures++; $display("FAIL midfill_data got=%h exp=%h", ks_data, exp_block(k, v, 0)); end
  endtask

  task automatic test_req_drop();
    bit ok, bad;
    bad = 1'b0;
    wait_ready(100, ok);
    req = 4'b0001;
    wait_valid(10, ok);
    req = 4'b0;
    tick();
    req = 4'b0100;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy_fill got=%b exp=1", busy); end
    tick();
    req = 4'b0;
    wait_ready(50, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL drop_ready_timeout got=%b exp=1", ok); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ks_valid !== 4'b0 || busy !== 1'b0 || core_next_data !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL drop_no_delivery got=%b exp=0", bad); end
    checks++; if (dut.state_q !== READY) begin failures++; $display("FAIL drop_state got=%0d exp=%0d", dut.state_q, READY); end
  endtask

  task automatic test_reset_mid_fill();
    bit ok, bad;
    bad = 1'b0;
    wait_ready(100, ok);
    req = 4'b0001;
    wait_valid(10, ok);
    req = 4'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ks_valid !== 4'b0) begin failures++; $display("FAIL rstfill_valid got=%b exp=0000", ks_valid); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL rstfill_state got=%0d exp=%0d", dut.state_q, IDLE); end
    checks++; if (ks_data !== 80'h0) begin failures++; $display("FAIL rstfill_data got=%h exp=0", ks_data); end
    checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL rstfill_core_rst got=%b exp=1", core_rst); end
    tick();
    rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ks_valid !== 4'b0) bad = 1'b1;
    end
    req = 4'b0;
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rstfill_no_valid got=%b exp=0", bad); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL rstfill_stays_idle got=%0d exp=%0d", dut.state_q, IDLE); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_multi();
    test_rekey_priority();
    test_rekey_mid_fill();
    test_req_drop();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule : tb_trivium_ks_arbiter
`default_nettype wire
